// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the memory stage.
// funct3 encodings and the bus FSM state type.
package pipe_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } mem_state_e;

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: picks the addressed byte/halfword
// out of the read word and sign- or zero-extends it.
module mem_load_align
  import pipe_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata_i[7:0];
    unique case (addr_lo_i)
      2'd0: b = rdata_i[7:0];
      2'd1: b = rdata_i[15:8];
      2'd2: b = rdata_i[23:16];
      2'd3: b = rdata_i[31:24];
    endcase
    h = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    data_o = rdata_i;
    unique case (funct3_i)
      F3_LB:   data_o = {{24{b[7]}}, b};
      F3_LH:   data_o = {{16{h[15]}}, h};
      F3_LBU:  data_o = {24'd0, b};
      F3_LHU:  data_o = {16'd0, h};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: one req/ack data-bus transaction per
// load/store, registered write-back, misalign/timeout fault.
module mem_stage
  import pipe_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_store_data,
  input  logic        in_write_reg,
  input  logic [4:0]  in_rd,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_write_reg,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        fault
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  mem_state_e  state_q;
  logic [CW-1:0] cnt_q;
  logic        req_q, we_q, wb_we_q, fault_q;
  logic [31:0] addr_q, wdata_q, wb_data_q;
  logic [3:0]  wstrb_q;
  logic [2:0]  f3_q;
  logic [1:0]  lo_q;
  logic        wr_q;
  logic [4:0]  rd_q, wb_rd_q;

  logic        mem_op, is_byte, is_half, misal_d;
  logic [3:0]  wstrb_d;
  logic [31:0] wdata_d, ld_data;

  always_comb begin
    mem_op  = in_mem_read | in_mem_write;
    is_byte = in_funct3[1:0] == F3_SB[1:0];
    is_half = in_funct3[1:0] == F3_SH[1:0];
    misal_d = 1'b0;
    wstrb_d = 4'b1111;
    wdata_d = in_store_data;
    unique case (1'b1)
      is_byte: begin
        wstrb_d = 4'b0001 << in_addr[1:0];
        wdata_d = {4{in_store_data[7:0]}};
      end
      is_half: begin
        misal_d = in_addr[0];
        wstrb_d = 4'b0011 << in_addr[1:0];
        wdata_d = {2{in_store_data[15:0]}};
      end
      default: misal_d = in_addr[1:0] != 2'b00;
    endcase
    if (!in_mem_write) begin
      wstrb_d = 4'b0000;
      wdata_d = 32'd0;
    end
  end

  mem_load_align u_align (
    .rdata_i   (dmem_rdata),
    .addr_lo_i (lo_q),
    .funct3_i  (f3_q),
    .data_o    (ld_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'd0;
      wstrb_q   <= 4'd0;
      wdata_q   <= 32'd0;
      f3_q      <= 3'd0;
      lo_q      <= 2'd0;
      wr_q      <= 1'b0;
      rd_q      <= 5'd0;
      wb_we_q   <= 1'b0;
      wb_rd_q   <= 5'd0;
      wb_data_q <= 32'd0;
      fault_q   <= 1'b0;
    end else begin
      wb_we_q <= 1'b0;
      fault_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (in_valid && !mem_op) begin
            wb_we_q   <= in_write_reg;
            wb_rd_q   <= in_rd;
            wb_data_q <= in_addr;
          end else if (in_valid && misal_d) begin
            fault_q <= 1'b1;
          end else if (in_valid) begin
            state_q <= S_BUSY;
            cnt_q   <= '0;
            req_q   <= 1'b1;
            we_q    <= in_mem_write;
            addr_q  <= {in_addr[31:2], 2'b00};
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
            f3_q    <= in_funct3;
            lo_q    <= in_addr[1:0];
            wr_q    <= in_write_reg;
            rd_q    <= in_rd;
          end
        end
        S_BUSY: begin
          // ack takes priority over an expiring timeout
          if (dmem_ack) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            cnt_q   <= '0;
            wb_we_q <= wr_q & ~we_q;
            wb_rd_q <= rd_q;
            if (!we_q) wb_data_q <= ld_data;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            cnt_q   <= '0;
            fault_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
      endcase
    end
  end

  assign stall        = state_q == S_BUSY;
  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wstrb   = wstrb_q;
  assign dmem_wdata   = wdata_q;
  assign wb_write_reg = wb_we_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign fault        = fault_q;

endmodule
